// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two client request/response channels and the memory-side
// control/data lines of mem_port_arbiter. The arbiter uses the slave view;
// clients plus the memory (or a bench standing in for them) use master.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int PSIZE = 4
);
  // client 0
  logic             c0_req_valid;
  logic             c0_req_ready;
  logic             c0_req_wr;
  logic [PSIZE-1:0] c0_req_addr;
  logic [WIDTH-1:0] c0_req_wdata;
  logic             c0_rsp_valid;
  logic [WIDTH-1:0] c0_rsp_rdata;

  // client 1
  logic             c1_req_valid;
  logic             c1_req_ready;
  logic             c1_req_wr;
  logic [PSIZE-1:0] c1_req_addr;
  logic [WIDTH-1:0] c1_req_wdata;
  logic             c1_rsp_valid;
  logic [WIDTH-1:0] c1_rsp_rdata;

  // memory side
  logic             mem_wr;
  logic             mem_rd;
  logic [PSIZE-1:0] mem_wr_addr;
  logic [PSIZE-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  c0_req_valid, c0_req_wr, c0_req_addr, c0_req_wdata,
    output c0_req_ready, c0_rsp_valid, c0_rsp_rdata,
    input  c1_req_valid, c1_req_wr, c1_req_addr, c1_req_wdata,
    output c1_req_ready, c1_rsp_valid, c1_rsp_rdata,
    output mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c0_req_valid, c0_req_wr, c0_req_addr, c0_req_wdata,
    input  c0_req_ready, c0_rsp_valid, c0_rsp_rdata,
    output c1_req_valid, c1_req_wr, c1_req_addr, c1_req_wdata,
    input  c1_req_ready, c1_rsp_valid, c1_rsp_rdata,
    input  mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter in front of a single-port register memory.
// At most one request is granted per cycle, so the memory never sees write
// and read together. Read data is routed back to the requesting client one
// cycle after issue; the memory itself supplies the registered read data.
// WIDTH must be even (the memory half-swaps words at upper addresses; this
// block passes data through untouched).
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int PSIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  // prio_q = 0 -> client 0 wins a tie, 1 -> client 1 wins a tie
  logic prio_q, prio_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  logic             gnt0;
  logic             gnt1;
  logic             gnt_any;
  logic             sel_wr;
  logic [PSIZE-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             issue_wr;
  logic             issue_rd;

  // Grant selection: a lone valid client always wins, a tie goes to prio.
  always_comb begin
    gnt0    = bus.c0_req_valid & (~bus.c1_req_valid | ~prio_q);
    gnt1    = bus.c1_req_valid & (~bus.c0_req_valid |  prio_q);
    gnt_any = gnt0 | gnt1;
  end

  // Mux the winning request; nothing leaks through without a grant.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_wr    = bus.c0_req_wr;
      sel_addr  = bus.c0_req_addr;
      sel_wdata = bus.c0_req_wdata;
    end else if (gnt1) begin
      sel_wr    = bus.c1_req_wr;
      sel_addr  = bus.c1_req_addr;
      sel_wdata = bus.c1_req_wdata;
    end
    issue_wr = gnt_any &  sel_wr;
    issue_rd = gnt_any & ~sel_wr;
  end

  // Memory-side drive; wr and rd come from one grant so they are exclusive.
  always_comb begin
    bus.mem_wr      = issue_wr;
    bus.mem_rd      = issue_rd;
    bus.mem_wr_addr = issue_wr ? sel_addr  : '0;
    bus.mem_rd_addr = issue_rd ? sel_addr  : '0;
    bus.mem_wdata   = issue_wr ? sel_wdata : '0;
    bus.c0_req_ready = gnt0;
    bus.c1_req_ready = gnt1;
  end

  // Next-state: pointer flips away from whoever was served; a read grant
  // books the response slot for the next cycle.
  always_comb begin
    prio_d     = gnt_any ? gnt0 : prio_q;
    rd_pend_d  = issue_rd;
    rd_owner_d = issue_rd ? gnt1 : rd_owner_q;
  end

  // State registers; reset drops any read in flight so it never responds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Response steering: only the owner sees valid and data, the other gets 0.
  always_comb begin
    bus.c0_rsp_valid = rd_pend_q & ~rd_owner_q;
    bus.c1_rsp_valid = rd_pend_q &  rd_owner_q;
    bus.c0_rsp_rdata = bus.c0_rsp_valid ? bus.mem_rdata : '0;
    bus.c1_rsp_rdata = bus.c1_rsp_valid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus pushes expected grants and
// responses (with the cycle they are due) into queues; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;
  localparam int WIDTH = 32;
  localparam int PSIZE = 4;
  localparam int DEPTH = 1 << PSIZE;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .PSIZE(PSIZE)) ifc ();

  mem_port_arbiter #(.WIDTH(WIDTH), .PSIZE(PSIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: write on the grant edge, registered read data,
  // upper-half addresses return the word with its halves swapped.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_rdata_q;
  always @(posedge clk) begin
    if (ifc.mem_wr) mem_q[ifc.mem_wr_addr] <= ifc.mem_wdata;
    if (ifc.mem_rd) begin
      if (ifc.mem_rd_addr[PSIZE-1])
        mem_rdata_q <= {mem_q[ifc.mem_rd_addr][WIDTH/2-1:0], mem_q[ifc.mem_rd_addr][WIDTH-1:WIDTH/2]};
      else
        mem_rdata_q <= mem_q[ifc.mem_rd_addr];
    end
  end
  assign ifc.mem_rdata = mem_rdata_q;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int               due;
    bit               cl;
    bit               wr;
    logic [PSIZE-1:0] addr;
    logic [WIDTH-1:0] data;
  } gnt_t;

  typedef struct {
    int               due;
    bit               cl;
    logic [WIDTH-1:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];

  task automatic exp_grant(input bit cl, input bit wr, input logic [PSIZE-1:0] a, input logic [WIDTH-1:0] d);
    gq.push_back('{cyc, cl, wr, a, d});
  endtask

  task automatic exp_rsp(input bit cl, input logic [WIDTH-1:0] d);
    rq.push_back('{cyc + 1, cl, d});
  endtask

  // Monitor: exclusivity, grants, responses and client hold-while-stalled.
  bit               exp_g, exp_r, ev0, ev1;
  gnt_t             g;
  bit               stall0, stall1;
  logic [WIDTH+PSIZE+1:0] hold0, hold1;
  always @(negedge clk) begin
    chk("mem_wr_rd_exclusive", {63'd0, ifc.mem_wr & ifc.mem_rd}, 64'd0);

    exp_g = (gq.size() > 0) && (gq[0].due <= cyc);
    chk("c0_req_ready", {63'd0, ifc.c0_req_ready}, {63'd0, exp_g && !gq[0].cl});
    chk("c1_req_ready", {63'd0, ifc.c1_req_ready}, {63'd0, exp_g &&  gq[0].cl});
    if (exp_g) begin
      g = gq.pop_front();
      if (g.wr) begin
        chk("mem_wr",      {63'd0, ifc.mem_wr}, 64'd1);
        chk("mem_rd",      {63'd0, ifc.mem_rd}, 64'd0);
        chk("mem_wr_addr", {60'd0, ifc.mem_wr_addr}, {60'd0, g.addr});
        chk("mem_wdata",   {32'd0, ifc.mem_wdata}, {32'd0, g.data});
      end else begin
        chk("mem_rd",      {63'd0, ifc.mem_rd}, 64'd1);
        chk("mem_wr",      {63'd0, ifc.mem_wr}, 64'd0);
        chk("mem_rd_addr", {60'd0, ifc.mem_rd_addr}, {60'd0, g.addr});
      end
    end else begin
      chk("idle_mem_ctl",  {62'd0, ifc.mem_wr, ifc.mem_rd}, 64'd0);
      chk("idle_mem_bus",  {24'd0, ifc.mem_wr_addr, ifc.mem_rd_addr, ifc.mem_wdata}, 64'd0);
    end

    exp_r = (rq.size() > 0) && (rq[0].due <= cyc);
    ev0 = exp_r && !rq[0].cl;
    ev1 = exp_r &&  rq[0].cl;
    chk("c0_rsp_valid", {63'd0, ifc.c0_rsp_valid}, {63'd0, ev0});
    chk("c1_rsp_valid", {63'd0, ifc.c1_rsp_valid}, {63'd0, ev1});
    chk("c0_rsp_rdata", {32'd0, ifc.c0_rsp_rdata}, ev0 ? {32'd0, rq[0].data} : 64'd0);
    chk("c1_rsp_rdata", {32'd0, ifc.c1_rsp_rdata}, ev1 ? {32'd0, rq[0].data} : 64'd0);
    if (exp_r) void'(rq.pop_front());

    if (stall0)
      chk("c0_hold_while_stalled",
          {{(62-WIDTH-PSIZE){1'b0}}, ifc.c0_req_valid, ifc.c0_req_wr, ifc.c0_req_addr, ifc.c0_req_wdata},
          {{(62-WIDTH-PSIZE){1'b0}}, hold0});
    if (stall1)
      chk("c1_hold_while_stalled",
          {{(62-WIDTH-PSIZE){1'b0}}, ifc.c1_req_valid, ifc.c1_req_wr, ifc.c1_req_addr, ifc.c1_req_wdata},
          {{(62-WIDTH-PSIZE){1'b0}}, hold1});
    stall0 = rst_n && ifc.c0_req_valid && !ifc.c0_req_ready;
    stall1 = rst_n && ifc.c1_req_valid && !ifc.c1_req_ready;
    hold0  = {ifc.c0_req_valid, ifc.c0_req_wr, ifc.c0_req_addr, ifc.c0_req_wdata};
    hold1  = {ifc.c1_req_valid, ifc.c1_req_wr, ifc.c1_req_addr, ifc.c1_req_wdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit v, input bit wr, input logic [PSIZE-1:0] a, input logic [WIDTH-1:0] d);
    ifc.c0_req_valid = v;
    ifc.c0_req_wr    = wr;
    ifc.c0_req_addr  = a;
    ifc.c0_req_wdata = d;
  endtask

  task automatic drive1(input bit v, input bit wr, input logic [PSIZE-1:0] a, input logic [WIDTH-1:0] d);
    ifc.c1_req_valid = v;
    ifc.c1_req_wr    = wr;
    ifc.c1_req_addr  = a;
    ifc.c1_req_wdata = d;
  endtask

  localparam logic [PSIZE-1:0] WA [4] = '{4'd5, 4'd6, 4'd7, 4'd9};
  localparam logic [WIDTH-1:0] WD [4] = '{32'hA5A5_0005, 32'hA5A5_0006, 32'hA5A5_0007, 32'hA5A5_0009};
  localparam logic [PSIZE-1:0] RA [3] = '{4'd3, 4'd12, 4'd5};
  localparam logic [WIDTH-1:0] RE [3] = '{32'hDEAD_BEEF, 32'h5678_1234, 32'hA5A5_0005};

  initial begin
    int w;
    int r;
    stall0 = 1'b0;
    stall1 = 1'b0;
    hold0  = '0;
    hold1  = '0;
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset held three cycles, then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // c0 write then read of addr 3
    drive0(1, 1, 4'd3, 32'hDEAD_BEEF);
    exp_grant(0, 1, 4'd3, 32'hDEAD_BEEF);
    tick();
    drive0(1, 0, 4'd3, '0);
    exp_grant(0, 0, 4'd3, '0);
    exp_rsp(0, 32'hDEAD_BEEF);
    tick();
    drive0(0, 0, '0, '0);
    repeat (2) tick();

    // c1 write then read of upper-half addr 12 (memory swaps halves)
    drive1(1, 1, 4'd12, 32'h1234_5678);
    exp_grant(1, 1, 4'd12, 32'h1234_5678);
    tick();
    drive1(1, 0, 4'd12, '0);
    exp_grant(1, 0, 4'd12, '0);
    exp_rsp(1, 32'h5678_1234);
    tick();
    drive1(0, 0, '0, '0);
    repeat (2) tick();

    // contention: c0 writes, c1 reads, both valid for 6 cycles;
    // the loser keeps its request stable until served
    w = 0;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      drive0(1, 1, WA[w], WD[w]);
      if (i < 6) drive1(1, 0, RA[r], '0);
      else       drive1(0, 0, '0, '0);
      if (i % 2 == 0) begin
        exp_grant(0, 1, WA[w], WD[w]);
        w++;
      end else begin
        exp_grant(1, 0, RA[r], '0);
        exp_rsp(1, RE[r]);
        r++;
      end
      tick();
    end
    drive0(0, 0, '0, '0);
    repeat (2) tick();

    // reset during the response cycle of a c0 read: no response, prio back to c0
    drive0(1, 0, 4'd3, '0);
    exp_grant(0, 0, 4'd3, '0);
    tick();
    drive0(0, 0, '0, '0);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_c0_rsp_valid", {63'd0, ifc.c0_rsp_valid}, 64'd0);
    chk("rst_async_c0_rsp_rdata", {32'd0, ifc.c0_rsp_rdata}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    drive0(1, 1, 4'd8, 32'hCAFE_F00D);
    drive1(1, 0, 4'd3, '0);
    exp_grant(0, 1, 4'd8, 32'hCAFE_F00D);
    tick();
    drive0(0, 0, '0, '0);
    exp_grant(1, 0, 4'd3, '0);
    exp_rsp(1, 32'hDEAD_BEEF);
    tick();
    drive1(0, 0, '0, '0);
    repeat (3) tick();

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("rsp_queue_drained",   64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
